// File: rtl/disp_bus_scan_if.sv
// Display-bus interface for disp_bus_scan: live inputs, packed display
// outputs and the multiplexed scan outputs. Parameters must match the
// N_DIGITS / DIGIT_W of the disp_bus_scan instance it is connected to.
interface disp_bus_scan_if #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 4
);
    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int DATA_W = N_DIGITS * DIGIT_W;

    logic [DATA_W-1:0]   data_in;
    logic [N_DIGITS-1:0] dot_in;
    logic                load;
    logic                hold;
    logic [DATA_W-1:0]   data;
    logic [N_DIGITS-1:0] dot;
    logic [IDX_W-1:0]    scan_idx;
    logic [N_DIGITS-1:0] scan_sel;
    logic [DIGIT_W-1:0]  scan_dig;
    logic                scan_dot;

    // Producer side: counter/lap logic drives the live value, sees the display.
    modport master (
        output data_in, dot_in, load, hold,
        input  data, dot, scan_idx, scan_sel, scan_dig, scan_dot
    );

    // Display stage side.
    modport slave (
        input  data_in, dot_in, load, hold,
        output data, dot, scan_idx, scan_sel, scan_dig, scan_dot
    );
endinterface

// File: rtl/disp_bus_scan.sv
// Stopwatch display-bus stage: live capture on load, lap-hold freeze of the
// packed display value, and a digit scanner that steps one digit every
// SCAN_DIV clocks for the 7-seg driver.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits (with no dots) in the scan outputs; packed outputs are unaffected.
module disp_bus_scan #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    disp_bus_scan_if.slave bus
);
    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int DATA_W = N_DIGITS * DIGIT_W;

    logic [DATA_W-1:0]   live_d;
    logic [N_DIGITS-1:0] live_p;
    logic [DATA_W-1:0]   next_data;
    logic [N_DIGITS-1:0] next_dot;
    logic [PRE_W-1:0]    presc;
    logic                wrap;
    logic [IDX_W-1:0]    next_idx;
    logic [N_DIGITS-1:0] blank;
    logic [N_DIGITS-1:0] next_sel;
    logic [DIGIT_W-1:0]  next_dig;
    logic                next_sdot;

    // Live stage: capture the running time on every load, regardless of hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_d <= '0;
            live_p <= '0;
        end else if (bus.load) begin
            live_d <= bus.data_in;
            live_p <= bus.dot_in;
        end
    end

    // Value the display registers take this edge; also feeds the scanner so
    // a wrap edge shows the post-update digit.
    always_comb begin
        next_data = bus.hold ? bus.data : live_d;
        next_dot  = bus.hold ? bus.dot  : live_p;
        wrap      = (presc == PRE_W'(SCAN_DIV - 1));
        next_idx  = (bus.scan_idx == IDX_W'(N_DIGITS - 1)) ? '0
                                                           : bus.scan_idx + IDX_W'(1);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_clear;

    // A digit is blank when it and everything above it is zero with no dots.
    always_comb begin
        blank       = '0;
        upper_clear = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            upper_clear = upper_clear && (next_data[i*DIGIT_W +: DIGIT_W] == '0)
                          && !next_dot[i];
            blank[i]    = upper_clear;
        end
    end
`else
    assign blank = '0;
`endif

    // Select the digit for the upcoming slot, honouring any blanking.
    always_comb begin
        next_sel  = '0;
        next_dig  = '0;
        next_sdot = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (next_idx == IDX_W'(i) && !blank[i]) begin
                next_sel[i] = 1'b1;
                next_dig    = next_data[i*DIGIT_W +: DIGIT_W];
                next_sdot   = next_dot[i];
            end
        end
    end

    // Display stage: follow the live value unless lap-hold freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data <= '0;
            bus.dot  <= '0;
        end else begin
            bus.data <= next_data;
            bus.dot  <= next_dot;
        end
    end

    // Slot prescaler: counts 0..SCAN_DIV-1 and wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (wrap) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    // Scan outputs advance together, only on slot wrap edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.scan_idx <= '0;
            bus.scan_sel <= N_DIGITS'(1);
            bus.scan_dig <= '0;
            bus.scan_dot <= 1'b0;
        end else if (wrap) begin
            bus.scan_idx <= next_idx;
            bus.scan_sel <= next_sel;
            bus.scan_dig <= next_dig;
            bus.scan_dot <= next_sdot;
        end
    end
endmodule

// File: tb/tb_disp_bus_scan.sv
// Testbench for disp_bus_scan: directed and random stimulus, a reference
// model of the display/scan behaviour and a queue-based scoreboard.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_disp_bus_scan;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int DIV = 4;
    localparam int DW  = N * W;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef logic [DW+N+2+N+W+1-1:0] snap_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    snap_t expQ[$];

    logic [DW-1:0] mLiveD, mData;
    logic [N-1:0]  mLiveP, mDot, mSel;
    logic [W-1:0]  mDig;
    logic          mSdot;
    int            mCnt, mIdx;

    always #5 clk = ~clk;

    disp_bus_scan_if #(.N_DIGITS(N), .DIGIT_W(W)) bus ();

    disp_bus_scan #(.N_DIGITS(N), .DIGIT_W(W), .SCAN_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic modelReset();
        mLiveD = '0; mLiveP = '0; mData = '0; mDot = '0;
        mCnt = 0; mIdx = 0;
        mSel = 4'b0001; mDig = '0; mSdot = 1'b0;
    endtask

    function automatic snap_t modelSnap();
        return {mData, mDot, 2'(mIdx), mSel, mDig, mSdot};
    endfunction

    function automatic snap_t dutSnap();
        return {bus.data, bus.dot, bus.scan_idx, bus.scan_sel, bus.scan_dig, bus.scan_dot};
    endfunction

    // One rising edge of the reference behaviour.
    task automatic modelStep();
        logic [DW-1:0] newData, upper;
        logic [N-1:0]  newDot;
        if (!rst_n) begin
            modelReset();
        end else begin
            newData = bus.hold ? mData : mLiveD;
            newDot  = bus.hold ? mDot  : mLiveP;
            if (mCnt == DIV - 1) begin
                mCnt  = 0;
                mIdx  = (mIdx + 1) % N;
                upper = newData >> (mIdx * W);
                if (BLANK && mIdx > 0 && upper == 0 && (newDot >> mIdx) == 0) begin
                    mSel = '0; mDig = '0; mSdot = 1'b0;
                end else begin
                    mSel  = 4'(1) << mIdx;
                    mDig  = upper[W-1:0];
                    mSdot = newDot[mIdx];
                end
            end else begin
                mCnt = mCnt + 1;
            end
            if (bus.load) begin
                mLiveD = bus.data_in;
                mLiveP = bus.dot_in;
            end
            mData = newData;
            mDot  = newDot;
        end
    endtask

    task automatic checkOutput(input string name, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got data/dot/idx/sel/dig/sdot=%h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Starts and ends at negedge+1: drive inputs, model the edge, queue the result.
    task automatic applyStimulus(input logic l, input logic h,
                                 input logic [DW-1:0] d, input logic [N-1:0] p);
        bus.load    = l;
        bus.hold    = h;
        bus.data_in = d;
        bus.dot_in  = p;
        @(posedge clk);
        modelStep();
        expQ.push_back(modelSnap());
        @(negedge clk);
        #1;
    endtask

    // Short asynchronous reset pulse entirely between clock edges.
    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset", dutSnap(), modelSnap());
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compare each queued expectation mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput("cycle", dutSnap(), expQ.pop_front());
        end
    end

    initial begin
        logic            h;
        logic [DW-1:0]   d;
        logic [N-1:0]    p;
        int              guard;
        bus.load = 1'b0; bus.hold = 1'b0; bus.data_in = '0; bus.dot_in = '0;
        modelReset();
        @(negedge clk);
        #1;
        repeat (2) applyStimulus(1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 16'h1234, 4'b0100);
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 4'b0);
        applyStimulus(1'b0, 1'b1, 16'h0, 4'b0);
        applyStimulus(1'b1, 1'b1, 16'h5678, 4'b0001);
        repeat (3) applyStimulus(1'b0, 1'b1, 16'h0, 4'b0);
        repeat (20) applyStimulus(1'b0, 1'b0, 16'h0, 4'b0);

        guard = 0;
        while (!(mIdx == 2 && mCnt == 1) && guard < 40) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 4'b0);
            guard++;
        end
        pulseReset();
        repeat (10) applyStimulus(1'b0, 1'b0, 16'h0, 4'b0);

        applyStimulus(1'b1, 1'b0, 16'h0050, 4'b0000);
        repeat (20) applyStimulus(1'b0, 1'b0, 16'h0, 4'b0);
        applyStimulus(1'b1, 1'b0, 16'h0050, 4'b1000);
        repeat (20) applyStimulus(1'b0, 1'b0, 16'h0, 4'b0);

        h = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) h = ~h;
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
            p = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            applyStimulus($urandom_range(0, 3) == 0, h, d, p);
            if ($urandom_range(0, 99) == 0) pulseReset();
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 4'b0);

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
